gat_layer_sched: RTL and testbench
==================================

// Module: gat_layer_sched
// PURPOSE
// - Run-level sequencer between the host register bank and gat_top: gates the three BRAM load-done flags into the core, drives gat_layer, detects gat_ready, steps through NUM_LAYERS layers.
// - Adds a load/clear handshake per layer, a per-layer cycle counter, a watchdog timeout and a completion IRQ pulse; debug words feed gat_debug_* in the register bank.
// PARAMETERS
// - TOP_WIDTH      32          register-bank word width; width of cycle/debug outputs
// - NUM_LAYERS     2           layers per run (1..2); layer index is 1 bit
// - TIMEOUT_CYC    32'd50000000  max cycles in S_RUN before timeout; 0 disables watchdog
// PORTS
// - clk                     in   1          system clock
// - rst_n                   in   1          asynchronous active-low reset
// - cfg_start               in   1          1-cycle pulse: begin a run (ignored unless S_IDLE/S_DONE/S_ERR)
// - cfg_abort               in   1          1-cycle pulse: return to S_IDLE from any state
// - host_h_data_done        in   1          level from register bank: H data BRAM loaded
// - host_h_node_info_done   in   1          level: H node-info BRAM loaded
// - host_wgt_done           in   1          level: weight BRAM loaded
// - core_h_data_done        out  1          to gat_top h_data_bram_load_done
// - core_h_node_info_done   out  1          to gat_top h_node_info_bram_load_done
// - core_wgt_done           out  1          to gat_top wgt_bram_load_done
// - gat_layer               out  1          layer select to gat_top (0 = layer 1)
// - gat_ready               in   1          level from gat_top; rising edge = layer complete
// - load_req                out  1          host may load BRAMs for layer gat_layer
// - sched_busy              out  1          high in every state except S_IDLE/S_DONE/S_ERR
// - sched_done              out  1          sticky; high in S_DONE
// - sched_err               out  1          sticky; high in S_ERR (timeout)
// - sched_irq               out  1          1-cycle pulse on entry to S_DONE or S_ERR
// - layer_cycles            out  TOP_WIDTH  cycles spent in S_RUN for current/last layer
// - total_cycles            out  TOP_WIDTH  cycles from start to S_DONE/S_ERR, saturating
// BEHAVIOUR
// - Reset: state S_IDLE; all outputs 0; counters 0; ready_q 0.
// - Outputs registered; state-change effects visible the cycle after the causing input.
// - ready_q <= gat_ready each cycle; ready_rise = gat_ready & ~ready_q.
// - all_done = host_h_data_done & host_h_node_info_done & host_wgt_done.
// - S_IDLE: cfg_start -> S_WAIT_CLR; clear layer=0, layer_cycles, total_cycles, sticky flags.
// - S_WAIT_CLR: load_req=0; wait all three host flags low (stale flags of previous layer/run) -> S_WAIT_LOAD.
// - S_WAIT_LOAD: load_req=1; all_done -> S_RUN, layer_cycles<=0. Partial flags: keep waiting.
// - S_RUN: load_req=0; core_*_done=1 (all three together, never individually); layer_cycles++ ;
//   ready_rise -> S_LAYER_END; layer_cycles==TIMEOUT_CYC-1 (TIMEOUT_CYC!=0) -> S_ERR.
//   ready_rise and timeout same cycle: ready wins.
//   gat_ready already high on S_RUN entry: not a rise; wait for low then high.
// - S_LAYER_END (1 cycle): core_*_done=0; if gat_layer==NUM_LAYERS-1 -> S_DONE else gat_layer<=gat_layer+1, -> S_WAIT_CLR.
// - S_DONE: sched_done=1; S_ERR: sched_err=1; both hold core_*_done=0, gat_layer unchanged; cfg_start -> S_WAIT_CLR as from S_IDLE.
// - cfg_abort (any state, priority over cfg_start and all transitions): -> S_IDLE next cycle, core_*_done=0, load_req=0, gat_layer=0, counters held, no irq.
// - total_cycles increments in every busy state, saturates at all-ones; layer_cycles held after leaving S_RUN.
// - Host flag drop during S_RUN: ignored (core flags held until S_LAYER_END).
// - Reset mid-run: asynchronous return to reset values; core flags drop immediately.
// STRUCTURE
// - Shared package (gat_pkg): sched_state_e enum {S_IDLE,S_WAIT_CLR,S_WAIT_LOAD,S_RUN,S_LAYER_END,S_DONE,S_ERR}; TOP_WIDTH constant.
// - Single module; optional sub-module gat_sat_counter (TOP_WIDTH, clr/en/sat) instantiated twice.
// - Use NUM_LAYERS=2 only for Citeseer build (NUM_FEATURE_FINAL defined); CORA builds set 1.
// TESTING
// - Reset with flags high -> all outputs 0, state S_IDLE; flags alone never reach core_*_done.
// - cfg_start, flags 0, raise three flags over 3 cycles, gat_ready rise 100 cyc later -> core_*_done high only after third flag, layer_cycles=100, NUM_LAYERS=1 -> sched_done, one irq pulse.
// - NUM_LAYERS=2: after layer 0 leave flags high -> held in S_WAIT_CLR, load_req=0; drop then raise -> gat_layer=1, second ready rise -> done.
// - TIMEOUT_CYC=16, no gat_ready -> sched_err after 16 S_RUN cycles, irq pulse, core flags 0; cfg_start restarts cleanly.
// - gat_ready high before S_RUN entry -> no completion until low-then-high; ready rise on timeout cycle -> completion, no error.
// - cfg_abort in S_RUN concurrent with ready rise and cfg_start -> S_IDLE, no irq, gat_layer=0.

Source files
------------

// File: rtl/gat_pkg.sv
// Shared types for the GAT run-level layer sequencer.
// Holds the scheduler state encoding and the register-bank word width.
package gat_pkg;

    localparam int unsigned TOP_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CLR,
        S_WAIT_LOAD,
        S_RUN,
        S_LAYER_END,
        S_DONE,
        S_ERR
    } sched_state_e;

    function automatic logic is_busy(sched_state_e s);
        return (s != S_IDLE) && (s != S_DONE) && (s != S_ERR);
    endfunction

endpackage

// File: rtl/gat_sat_counter.sv
// Cycle counter with synchronous clear and count enable.
// When SAT is set it sticks at all-ones instead of wrapping.
module gat_sat_counter #(
    parameter int unsigned WIDTH = 32,
    parameter bit          SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic at_max;

    assign at_max = SAT && (&count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/gat_layer_sched.sv
// Run-level sequencer: gates BRAM load-done flags into gat_top and walks
// through the layers, with per-layer load handshake, watchdog and IRQ.
module gat_layer_sched #(
    parameter int unsigned TOP_WIDTH   = gat_pkg::TOP_WIDTH,
    parameter int unsigned NUM_LAYERS  = 2,
    parameter logic [31:0] TIMEOUT_CYC = 32'd50000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic                 host_h_data_done,
    input  logic                 host_h_node_info_done,
    input  logic                 host_wgt_done,
    output logic                 core_h_data_done,
    output logic                 core_h_node_info_done,
    output logic                 core_wgt_done,
    output logic                 gat_layer,
    input  logic                 gat_ready,
    output logic                 load_req,
    output logic                 sched_busy,
    output logic                 sched_done,
    output logic                 sched_err,
    output logic                 sched_irq,
    output logic [TOP_WIDTH-1:0] layer_cycles,
    output logic [TOP_WIDTH-1:0] total_cycles
);

    import gat_pkg::*;

    localparam logic [TOP_WIDTH-1:0] TO_LAST = TOP_WIDTH'(TIMEOUT_CYC - 32'd1);
    localparam logic LAST_LAYER = 1'(NUM_LAYERS - 1);

    sched_state_e state, state_d;

    logic ready_q;
    logic ready_rise;
    logic all_done;
    logic any_flag;
    logic timeout_hit;
    logic last_layer;
    logic start_ok;
    logic core_q;
    logic core_d;
    logic load_d;
    logic busy_d;
    logic irq_d;
    logic lc_clr;
    logic lc_en;
    logic tc_en;

    assign all_done   = host_h_data_done & host_h_node_info_done & host_wgt_done;
    assign any_flag   = host_h_data_done | host_h_node_info_done | host_wgt_done;
    assign ready_rise = gat_ready & ~ready_q;
    assign last_layer = (gat_layer == LAST_LAYER);
    assign timeout_hit = (TIMEOUT_CYC != 32'd0) && (layer_cycles == TO_LAST);
    assign start_ok   = cfg_start && !cfg_abort &&
                        (state == S_IDLE || state == S_DONE || state == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_d;
            ready_q <= gat_ready;
        end
    end

    // Abort overrides every transition; a ready edge beats the watchdog.
    always_comb begin
        state_d = state;
        if (cfg_abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_ERR: if (cfg_start) state_d = S_WAIT_CLR;
                S_WAIT_CLR:  if (!any_flag) state_d = S_WAIT_LOAD;
                S_WAIT_LOAD: if (all_done) state_d = S_RUN;
                S_RUN: begin
                    if (ready_rise) state_d = S_LAYER_END;
                    else if (timeout_hit) state_d = S_ERR;
                end
                S_LAYER_END: state_d = last_layer ? S_DONE : S_WAIT_CLR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        core_d = (state_d == S_RUN);
        load_d = (state_d == S_WAIT_LOAD);
        busy_d = is_busy(state_d);
        irq_d  = (state_d != state) && (state_d == S_DONE || state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_q     <= 1'b0;
            load_req   <= 1'b0;
            sched_busy <= 1'b0;
            sched_irq  <= 1'b0;
            sched_done <= 1'b0;
            sched_err  <= 1'b0;
            gat_layer  <= 1'b0;
        end else begin
            core_q     <= core_d;
            load_req   <= load_d;
            sched_busy <= busy_d;
            sched_irq  <= irq_d;
            if (start_ok) begin
                sched_done <= 1'b0;
                sched_err  <= 1'b0;
            end else begin
                if (state_d == S_DONE) sched_done <= 1'b1;
                if (state_d == S_ERR)  sched_err  <= 1'b1;
            end
            if (cfg_abort || start_ok) begin
                gat_layer <= 1'b0;
            end else if (state == S_LAYER_END && !last_layer) begin
                gat_layer <= gat_layer + 1'b1;
            end
        end
    end

    assign core_h_data_done      = core_q;
    assign core_h_node_info_done = core_q;
    assign core_wgt_done         = core_q;

    assign lc_clr = start_ok || (state == S_WAIT_LOAD && state_d == S_RUN);
    assign lc_en  = (state == S_RUN) && !cfg_abort;
    assign tc_en  = is_busy(state) && !cfg_abort;

    gat_sat_counter #(
        .WIDTH (TOP_WIDTH),
        .SAT   (1'b1)
    ) u_layer_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (lc_clr),
        .en    (lc_en),
        .count (layer_cycles)
    );

    gat_sat_counter #(
        .WIDTH (TOP_WIDTH),
        .SAT   (1'b1)
    ) u_total_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .en    (tc_en),
        .count (total_cycles)
    );

endmodule

// File: tb/tb_gat_layer_sched.sv
// Bench for gat_layer_sched: one single-layer/no-watchdog instance and one
// two-layer instance with a 16-cycle watchdog, randomized run lengths.
module tb_gat_layer_sched;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] start;
    logic abort;
    logic fh, fn, fw;
    logic rdy;

    logic [1:0] core_h, core_n, core_w, layer;
    logic [1:0] load_req, busy, done, err, irq;
    logic [31:0] lcyc [2];
    logic [31:0] tcyc [2];

    int total = 0;
    int bad = 0;
    int irq_cnt0 = 0;
    int irq_cnt1 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (irq[0]) irq_cnt0 <= irq_cnt0 + 1;
        if (irq[1]) irq_cnt1 <= irq_cnt1 + 1;
    end

    gat_layer_sched #(
        .TOP_WIDTH   (32),
        .NUM_LAYERS  (1),
        .TIMEOUT_CYC (32'd0)
    ) u_one (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .cfg_start             (start[0]),
        .cfg_abort             (abort),
        .host_h_data_done      (fh),
        .host_h_node_info_done (fn),
        .host_wgt_done         (fw),
        .core_h_data_done      (core_h[0]),
        .core_h_node_info_done (core_n[0]),
        .core_wgt_done         (core_w[0]),
        .gat_layer             (layer[0]),
        .gat_ready             (rdy),
        .load_req              (load_req[0]),
        .sched_busy            (busy[0]),
        .sched_done            (done[0]),
        .sched_err             (err[0]),
        .sched_irq             (irq[0]),
        .layer_cycles          (lcyc[0]),
        .total_cycles          (tcyc[0])
    );

    gat_layer_sched #(
        .TOP_WIDTH   (32),
        .NUM_LAYERS  (2),
        .TIMEOUT_CYC (32'd16)
    ) u_two (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .cfg_start             (start[1]),
        .cfg_abort             (abort),
        .host_h_data_done      (fh),
        .host_h_node_info_done (fn),
        .host_wgt_done         (fw),
        .core_h_data_done      (core_h[1]),
        .core_h_node_info_done (core_n[1]),
        .core_wgt_done         (core_w[1]),
        .gat_layer             (layer[1]),
        .gat_ready             (rdy),
        .load_req              (load_req[1]),
        .sched_busy            (busy[1]),
        .sched_done            (done[1]),
        .sched_err             (err[1]),
        .sched_irq             (irq[1]),
        .layer_cycles          (lcyc[1]),
        .total_cycles          (tcyc[1])
    );

    function automatic logic [2:0] core3(bit d);
        return {core_h[d], core_n[d], core_w[d]};
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    // Start pulse with host flags already clear: lands in S_WAIT_CLR.
    task automatic drive_start(bit d);
        {fh, fn, fw} = 3'b000;
        start[d] = 1'b1;
        tick(1);
        start[d] = 1'b0;
    endtask

    // One cycle in S_WAIT_CLR, one in S_WAIT_LOAD, then in S_RUN.
    task automatic load_and_run();
        tick(1);
        {fh, fn, fw} = 3'b111;
        tick(1);
    endtask

    // n quiet S_RUN cycles, then a ready edge; ends in S_LAYER_END.
    task automatic finish_layer(int n);
        tick(n);
        rdy = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        logic [17:0] bits;
        logic [127:0] cnts;
        rst_n = 1'b0;
        start = 2'b00;
        abort = 1'b0;
        {fh, fn, fw} = 3'b111;
        rdy = 1'b1;
        tick(3);
        bits = {core_h, core_n, core_w, layer, load_req, busy, done, err, irq};
        total++; if (bits !== 18'd0) begin bad++; $display("FAIL reset_outputs: got %b want 0", bits); end
        cnts = {lcyc[0], lcyc[1], tcyc[0], tcyc[1]};
        total++; if (cnts !== 128'd0) begin bad++; $display("FAIL reset_counters: got %h want 0", cnts); end
        rst_n = 1'b1;
        tick(4);
        bits = {core_h, core_n, core_w, load_req, busy, irq, 6'd0};
        total++; if (bits !== 18'd0) begin bad++; $display("FAIL flags_only_idle: got %b want 0", bits); end
    endtask

    task automatic test_single_layer();
        for (int it = 0; it < 3; it++) begin
            int g1, g2, n, base;
            g1 = (it == 0) ? 1 : int'($urandom_range(1, 4));
            g2 = (it == 0) ? 1 : int'($urandom_range(1, 4));
            n = (it == 0) ? 99 : int'($urandom_range(20, 120));
            base = irq_cnt0;
            rdy = 1'b0;
            drive_start(1'b0);
            total++; if ({busy[0], load_req[0]} !== 2'b10) begin bad++; $display("FAIL single_clr: got %b want 10", {busy[0], load_req[0]}); end
            tick(1);
            total++; if (load_req[0] !== 1'b1) begin bad++; $display("FAIL single_loadreq: got %b want 1", load_req[0]); end
            fh = 1'b1;
            repeat (g1) begin
                tick(1);
                total++; if (core3(1'b0) !== 3'b000) begin bad++; $display("FAIL single_partial1: got %b want 000", core3(1'b0)); end
            end
            fn = 1'b1;
            repeat (g2) begin
                tick(1);
                total++; if (core3(1'b0) !== 3'b000) begin bad++; $display("FAIL single_partial2: got %b want 000", core3(1'b0)); end
            end
            fw = 1'b1;
            tick(1);
            total++; if ({core3(1'b0), load_req[0]} !== 4'b1110) begin bad++; $display("FAIL single_run: got %b want 1110", {core3(1'b0), load_req[0]}); end
            finish_layer(n);
            total++; if ({core3(1'b0), done[0]} !== 4'b0000) begin bad++; $display("FAIL single_layer_end: got %b want 0000", {core3(1'b0), done[0]}); end
            tick(1);
            total++; if ({done[0], irq[0], busy[0]} !== 3'b110) begin bad++; $display("FAIL single_done: got %b want 110", {done[0], irq[0], busy[0]}); end
            total++; if (lcyc[0] !== 32'(n + 1)) begin bad++; $display("FAIL single_lcyc: got %0d want %0d", lcyc[0], n + 1); end
            total++; if (tcyc[0] !== 32'(g1 + g2 + n + 4)) begin bad++; $display("FAIL single_tcyc: got %0d want %0d", tcyc[0], g1 + g2 + n + 4); end
            tick(1);
            total++; if ({done[0], irq[0]} !== 2'b10) begin bad++; $display("FAIL single_irq_pulse: got %b want 10", {done[0], irq[0]}); end
            total++; if (irq_cnt0 - base !== 1) begin bad++; $display("FAIL single_irq_count: got %0d want 1", irq_cnt0 - base); end
        end
    endtask

    task automatic test_two_layers();
        for (int it = 0; it < 2; it++) begin
            int n1, n2, h, base;
            n1 = int'($urandom_range(1, 12));
            n2 = int'($urandom_range(1, 12));
            h = int'($urandom_range(1, 5));
            base = irq_cnt1;
            rdy = 1'b0;
            drive_start(1'b1);
            load_and_run();
            total++; if ({core3(1'b1), layer[1]} !== 4'b1110) begin bad++; $display("FAIL two_run0: got %b want 1110", {core3(1'b1), layer[1]}); end
            finish_layer(n1);
            tick(1);
            total++; if ({layer[1], load_req[1], busy[1], irq[1]} !== 4'b1010) begin bad++; $display("FAIL two_next_layer: got %b want 1010", {layer[1], load_req[1], busy[1], irq[1]}); end
            rdy = 1'b0;
            repeat (h) begin
                tick(1);
                total++; if ({load_req[1], core3(1'b1)} !== 4'b0000) begin bad++; $display("FAIL two_stale_hold: got %b want 0000", {load_req[1], core3(1'b1)}); end
            end
            {fh, fn, fw} = 3'b000;
            tick(1);
            total++; if (load_req[1] !== 1'b1) begin bad++; $display("FAIL two_loadreq1: got %b want 1", load_req[1]); end
            {fh, fn, fw} = 3'b111;
            tick(1);
            total++; if ({core3(1'b1), layer[1]} !== 4'b1111) begin bad++; $display("FAIL two_run1: got %b want 1111", {core3(1'b1), layer[1]}); end
            finish_layer(n2);
            tick(1);
            total++; if ({done[1], irq[1], layer[1], busy[1]} !== 4'b1110) begin bad++; $display("FAIL two_done: got %b want 1110", {done[1], irq[1], layer[1], busy[1]}); end
            total++; if (lcyc[1] !== 32'(n2 + 1)) begin bad++; $display("FAIL two_lcyc: got %0d want %0d", lcyc[1], n2 + 1); end
            total++; if (tcyc[1] !== 32'(n1 + n2 + h + 8)) begin bad++; $display("FAIL two_tcyc: got %0d want %0d", tcyc[1], n1 + n2 + h + 8); end
            tick(1);
            total++; if (irq_cnt1 - base !== 1) begin bad++; $display("FAIL two_irq_count: got %0d want 1", irq_cnt1 - base); end
        end
    endtask

    task automatic test_timeout();
        rdy = 1'b0;
        drive_start(1'b1);
        load_and_run();
        tick(15);
        total++; if ({err[1], core3(1'b1)} !== 4'b0111) begin bad++; $display("FAIL to_before: got %b want 0111", {err[1], core3(1'b1)}); end
        tick(1);
        total++; if ({err[1], irq[1], busy[1], core3(1'b1), layer[1]} !== 7'b1100000) begin bad++; $display("FAIL to_err: got %b want 1100000", {err[1], irq[1], busy[1], core3(1'b1), layer[1]}); end
        total++; if (lcyc[1] !== 32'd16) begin bad++; $display("FAIL to_lcyc: got %0d want 16", lcyc[1]); end
        total++; if (tcyc[1] !== 32'd18) begin bad++; $display("FAIL to_tcyc: got %0d want 18", tcyc[1]); end
        tick(1);
        total++; if ({err[1], irq[1]} !== 2'b10) begin bad++; $display("FAIL to_sticky: got %b want 10", {err[1], irq[1]}); end
        {fh, fn, fw} = 3'b111;
        start[1] = 1'b1;
        tick(1);
        start[1] = 1'b0;
        total++; if ({err[1], busy[1], load_req[1]} !== 3'b010) begin bad++; $display("FAIL to_restart: got %b want 010", {err[1], busy[1], load_req[1]}); end
        total++; if ({lcyc[1], tcyc[1]} !== 64'd0) begin bad++; $display("FAIL to_restart_cnt: got %h want 0", {lcyc[1], tcyc[1]}); end
        {fh, fn, fw} = 3'b000;
        load_and_run();
        finish_layer(3);
        tick(1);
        total++; if ({layer[1], err[1], done[1]} !== 3'b100) begin bad++; $display("FAIL to_restart_layer: got %b want 100", {layer[1], err[1], done[1]}); end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
    endtask

    task automatic test_ready_on_timeout();
        rdy = 1'b0;
        drive_start(1'b1);
        load_and_run();
        tick(15);
        rdy = 1'b1;
        tick(1);
        total++; if ({err[1], core3(1'b1), busy[1]} !== 5'b00001) begin bad++; $display("FAIL rot_end: got %b want 00001", {err[1], core3(1'b1), busy[1]}); end
        total++; if (lcyc[1] !== 32'd16) begin bad++; $display("FAIL rot_lcyc: got %0d want 16", lcyc[1]); end
        tick(1);
        total++; if ({layer[1], err[1], irq[1]} !== 3'b100) begin bad++; $display("FAIL rot_next: got %b want 100", {layer[1], err[1], irq[1]}); end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
    endtask

    task automatic test_ready_held();
        rdy = 1'b1;
        drive_start(1'b1);
        load_and_run();
        tick(4);
        total++; if (core3(1'b1) !== 3'b111) begin bad++; $display("FAIL held_no_rise: got %b want 111", core3(1'b1)); end
        rdy = 1'b0;
        tick(1);
        total++; if (core3(1'b1) !== 3'b111) begin bad++; $display("FAIL held_low: got %b want 111", core3(1'b1)); end
        rdy = 1'b1;
        tick(1);
        total++; if (core3(1'b1) !== 3'b000) begin bad++; $display("FAIL held_rise: got %b want 000", core3(1'b1)); end
        total++; if (lcyc[1] !== 32'd6) begin bad++; $display("FAIL held_lcyc: got %0d want 6", lcyc[1]); end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
    endtask

    task automatic test_abort();
        int n0, n, base;
        n0 = int'($urandom_range(1, 5));
        n = int'($urandom_range(1, 12));
        base = irq_cnt1;
        rdy = 1'b0;
        drive_start(1'b1);
        load_and_run();
        finish_layer(n0);
        tick(1);
        {fh, fn, fw} = 3'b000;
        rdy = 1'b0;
        load_and_run();
        tick(n);
        total++; if ({layer[1], core3(1'b1)} !== 4'b1111) begin bad++; $display("FAIL abort_pre: got %b want 1111", {layer[1], core3(1'b1)}); end
        abort = 1'b1;
        start[1] = 1'b1;
        rdy = 1'b1;
        tick(1);
        abort = 1'b0;
        start[1] = 1'b0;
        total++; if ({busy[1], load_req[1], irq[1], err[1], core3(1'b1), layer[1]} !== 8'd0) begin bad++; $display("FAIL abort_idle: got %b want 0", {busy[1], load_req[1], irq[1], err[1], core3(1'b1), layer[1]}); end
        total++; if (lcyc[1] !== 32'(n)) begin bad++; $display("FAIL abort_lcyc: got %0d want %0d", lcyc[1], n); end
        total++; if (tcyc[1] !== 32'(n0 + n + 6)) begin bad++; $display("FAIL abort_tcyc: got %0d want %0d", tcyc[1], n0 + n + 6); end
        tick(2);
        total++; if (busy[1] !== 1'b0) begin bad++; $display("FAIL abort_stay: got %b want 0", busy[1]); end
        total++; if (irq_cnt1 !== base) begin bad++; $display("FAIL abort_irq: got %0d want %0d", irq_cnt1, base); end
    endtask

    task automatic test_reset_midrun();
        rdy = 1'b0;
        drive_start(1'b1);
        load_and_run();
        tick(3);
        total++; if (core3(1'b1) !== 3'b111) begin bad++; $display("FAIL mid_pre: got %b want 111", core3(1'b1)); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if ({core3(1'b1), busy[1]} !== 4'b0000) begin bad++; $display("FAIL mid_async: got %b want 0000", {core3(1'b1), busy[1]}); end
        total++; if ({lcyc[1], tcyc[1]} !== 64'd0) begin bad++; $display("FAIL mid_cnt: got %h want 0", {lcyc[1], tcyc[1]}); end
        tick(1);
        rst_n = 1'b1;
        tick(2);
        total++; if ({core3(1'b1), busy[1], load_req[1]} !== 5'b00000) begin bad++; $display("FAIL mid_after: got %b want 00000", {core3(1'b1), busy[1], load_req[1]}); end
    endtask

    initial begin
        test_reset();
        test_single_layer();
        test_two_layers();
        test_timeout();
        test_ready_on_timeout();
        test_ready_held();
        test_abort();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
